// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types and constants for the uart_tx / uart_rx pair.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Brief    : Receive-side byte handshake and status flags of the UART core.
// Revision : 1.0
// ============================================================================
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);

    logic [DATA_BITS-1:0] dout;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 busy_rx;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output dout, rx_valid, busy_rx, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  dout, rx_valid, busy_rx, frame_err, overrun,
        output rx_ready
    );

endinterface
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync2
// Brief    : Two-flop synchroniser for an asynchronous single-bit input.
// Revision : 1.0
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_q    <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver, mid-bit sampling on an oversample clock,
//            valid/ready byte output with framing-error and overrun pulses.
// Revision : 1.0
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic       baud_clk,
    input  logic       nrst,
    input  logic       sin,
    uart_rx_if.master  bus
);

    localparam int                  c_CW       = $clog2(OVERSAMPLE);
    localparam logic [c_CW-1:0]     c_HALF_M1  = c_CW'(OVERSAMPLE/2 - 1);
    localparam logic [c_CW-1:0]     c_FULL_M1  = c_CW'(OVERSAMPLE - 1);
    localparam logic [2:0]          c_LAST_BIT = 3'(DATA_BITS - 1);

    logic                 w_sin_s;
    uart_rx_state_t       r_state, w_state_nxt;
    logic [c_CW-1:0]      r_cnt, w_cnt_nxt;
    logic [2:0]           r_bit, w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 w_done, w_ferr;

    logic [DATA_BITS-1:0] r_dout;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_ovr;

    // Idle line is high, so the synchroniser resets to 1 to avoid a false start.
    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (baud_clk),
        .rst (nrst),
        .i_d (sin),
        .o_q (w_sin_s)
    );

    always_ff @(posedge baud_clk) begin
        if (nrst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (!w_sin_s) w_state_nxt = START;
            end
            START: begin
                if (r_cnt == c_HALF_M1) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = w_sin_s ? IDLE : DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_sin_s, r_shift[DATA_BITS-1:1]};
                    if (r_bit == c_LAST_BIT) w_state_nxt = STOP;
                    else                     w_bit_nxt   = r_bit + 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            STOP: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_nxt = '0;
                    if (w_sin_s) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = WAIT_HIGH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            // Hold off until a break releases so it cannot look like a new start bit.
            WAIT_HIGH: begin
                w_cnt_nxt = '0;
                if (w_sin_s) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (nrst) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            r_ovr  <= 1'b0;
            // A consumer accepting on the completion edge frees the slot for the new byte.
            if (w_done) begin
                if (!r_valid || bus.rx_ready) begin
                    r_dout  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr   <= 1'b1;
                end
            end else if (r_valid && bus.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.dout      = r_dout;
    assign bus.rx_valid  = r_valid;
    assign bus.busy_rx   = (r_state != IDLE);
    assign bus.frame_err = r_ferr;
    assign bus.overrun   = r_ovr;

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It is the receive-side counterpart of uart_tx in the same UART core.
- Runs on baud_clk, defined here as an oversample clock at OVERSAMPLE times the bit rate.
- Synchronises the serial input and detects the start bit.
- Samples each bit at mid-bit.
- Presents each received byte through a valid/ready handshake, with framing-error and overrun flags.

Parameters:
- OVERSAMPLE, 16, baud_clk cycles per bit; must be even and >= 4.
- DATA_BITS, 8, data bits per frame; only 8 is verified.

Ports:
- baud_clk  input  1  clock; OVERSAMPLE x bit rate.
- nrst  input  1  reset; synchronous, active-high.
- sin  input  1  asynchronous serial line; idles high.
- dout  output  8  received byte; valid while rx_valid=1.
- rx_valid  output  1  byte available; held until consumed.
- rx_ready  input  1  consumer accepts dout at a baud_clk edge when rx_valid=1.
- busy_rx  output  1  high whenever FSM is not IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: new byte completed while previous still unconsumed.

Behaviour:
- Reset:
  - nrst=1 at a baud_clk edge forces IDLE and clears the counters.
  - Both synchroniser flops are set to 1.
  - All outputs go to 0: dout=0, rx_valid=0, busy_rx=0, frame_err=0, overrun=0.
  - Reset has priority over everything, including mid-frame and during a pending rx_valid.
- Synchroniser: 2 flops on sin. The FSM uses only the second flop output (sin_s).
- Cycle numbering: edge 0 is the first edge at which flop 1 samples sin low. sin_s is low after edge 1, and the FSM enters START at edge 2.
- FSM states:
  - IDLE: cnt=0. When sin_s=0, go to START.
  - START: cnt counts up. At OVERSAMPLE/2 edges after entry, re-check sin_s.
    - If sin_s=1, this is a glitch: go to IDLE with no outputs.
    - Otherwise reset cnt, set bit index=0, go to DATA.
  - DATA: every OVERSAMPLE edges, shift sin_s into the shift register from the MSB side, so bit 0 ends up in dout[0]. After bit 7 is sampled, go to STOP.
  - STOP: OVERSAMPLE edges after bit 7, sample sin_s.
    - If 1: complete the byte (see handshake), then go to IDLE.
    - If 0: pulse frame_err for 1 cycle, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until sin_s=1, then go to IDLE. This stops a break condition from retriggering reception.
- Latency at OVERSAMPLE=16:
  - Start re-check at edge 10.
  - Bit n sampled at edge 26+16n.
  - Stop sampled at edge 154.
  - dout, rx_valid and frame_err update on edge 154.
  - General form: 2 + OVERSAMPLE/2 + 9*OVERSAMPLE.
- Handshake:
  - rx_valid rises on byte completion and stays high until an edge where rx_valid=1 and rx_ready=1. It clears on that edge unless a new byte completes on the same edge.
  - dout is stable while rx_valid=1.
- Completion with rx_valid=1:
  - rx_ready=0 on that edge: drop the new byte, pulse overrun for 1 cycle, dout and rx_valid unchanged.
  - rx_ready=1 on that edge: load the new byte, rx_valid stays 1, no overrun.
- Frame error with rx_valid=1: the pending byte is untouched and overrun is not asserted.
- rx_ready while rx_valid=0 is ignored.
- busy_rx is asserted in START, DATA, STOP and WAIT_HIGH.
- Counters:
  - cnt width is $clog2(OVERSAMPLE). It resets at every sample point and never wraps mid-bit.
  - Bit index is 3 bits.

Decomposition:
- Package uart_pkg holds:
  - typedef enum uart_rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH}
  - constants UART_DATA_BITS=8 and UART_OVERSAMPLE=16, shared with uart_tx.
- Sub-module uart_sync2: a 2-flop synchroniser with a reset value parameter, here set to 1. It is reusable for other asynchronous inputs.

Test Plan:
- Reset: nrst=1 for 2 edges with sin=1 -> dout=8'h00; rx_valid, busy_rx, frame_err and overrun all 0; FSM in IDLE.
- Clean frame 8'hA5 (line sequence 0,1,0,1,0,0,1,0,1,1), 16 cycles/bit, rx_ready=0 -> rx_valid=1 and dout=8'hA5 at edge 154. Held 50 cycles; rx_ready=1 for one edge clears rx_valid on that edge.
- Glitch: sin low for 4 cycles, then high -> busy_rx rises at edge 2 and falls after the edge-10 check; rx_valid and frame_err stay 0.
- Framing error: 8'h3C with stop bit 0, line low 20 more cycles, then high -> frame_err 1-cycle pulse at edge 154, rx_valid=0. busy_rx stays high until 2 edges after the line returns high, then IDLE.
- Overrun: 8'h11 then 8'h22 back-to-back, rx_ready=0 -> overrun pulse on the second completion, dout=8'h11. Repeat with rx_ready=1 exactly on the second completion edge -> dout=8'h22, rx_valid stays 1, no overrun.
- Reset mid-frame: nrst=1 for 1 edge during bit 3 of 8'hFF -> outputs cleared at that edge. A following clean 8'h5A frame is received with dout=8'h5A at its edge 154.
